// File: rtl/mem_stg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stg
//  Purpose  : Memory stage of the 8-bit RISC pipeline. Holds the byte-wide
//             data memory, performs loads and stores, and registers the
//             MEM/WB latch that feeds write-back plus a forwarding port
//             back to execute.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             stall, flush           - hold stage / squash incoming instr
//             valid_in, pipe_stg_in  - instruction valid and stage tag
//             alu_result             - ALU result and memory address
//             store_data, imm_in     - store data, load-immediate value
//             rd_in, reg_write_in    - destination reg and its write enable
//             mem_read, mem_write    - load / store strobes
//             wb_sel_in              - 0 = immediate, 1 = result
//             wb_*                   - registered MEM/WB latch
//             fwd_*                  - forwarding decode of the latch
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stg #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        pipe_stg_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [1:0]        rd_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              wb_sel_in,
    input  logic              reg_write_in,
    output logic [DATA_W-1:0] wb_imm,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_sel,
    output logic [1:0]        wb_rd,
    output logic [3:0]        wb_pipe_stg,
    output logic              wb_reg_write,
    output logic              wb_valid,
    output logic              fwd_valid,
    output logic [1:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [C_DEPTH];

    logic [DATA_W-1:0] wb_imm_q,       wb_imm_d;
    logic [DATA_W-1:0] wb_result_q,    wb_result_d;
    logic              wb_sel_q,       wb_sel_d;
    logic [1:0]        wb_rd_q,        wb_rd_d;
    logic [3:0]        wb_pipe_stg_q,  wb_pipe_stg_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_valid_q,     wb_valid_d;

    logic              w_accept;
    logic              w_bubble;
    logic              w_store_en;
    logic [ADDR_W-1:0] w_addr;

    // Upper address bits are dropped so accesses wrap inside the memory.
    assign w_addr     = alu_result[ADDR_W-1:0];
    assign w_accept   = valid_in & ~stall & ~flush;
    // Flush overrides stall; an invalid, unstalled slot also becomes a bubble.
    assign w_bubble   = flush | (~stall & ~valid_in);
    assign w_store_en = w_accept & mem_write;

    always_comb begin
        wb_imm_d       = wb_imm_q;
        wb_result_d    = wb_result_q;
        wb_sel_d       = wb_sel_q;
        wb_rd_d        = wb_rd_q;
        wb_pipe_stg_d  = wb_pipe_stg_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_valid_d     = wb_valid_q;
        if (w_bubble) begin
            wb_valid_d     = 1'b0;
            wb_reg_write_d = 1'b0;
        end else if (w_accept) begin
            wb_imm_d       = imm_in;
            wb_sel_d       = wb_sel_in;
            wb_rd_d        = rd_in;
            wb_pipe_stg_d  = pipe_stg_in;
            wb_reg_write_d = reg_write_in;
            wb_valid_d     = 1'b1;
            // Read-before-write: a load sees memory as it was before this edge.
            // Read+write together is treated as a store returning alu_result.
            if (mem_read && !mem_write) begin
                wb_result_d = mem_q[w_addr];
            end else begin
                wb_result_d = alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_imm_q       <= '0;
            wb_result_q    <= '0;
            wb_sel_q       <= 1'b0;
            wb_rd_q        <= '0;
            wb_pipe_stg_q  <= '0;
            wb_reg_write_q <= 1'b0;
            wb_valid_q     <= 1'b0;
        end else begin
            wb_imm_q       <= wb_imm_d;
            wb_result_q    <= wb_result_d;
            wb_sel_q       <= wb_sel_d;
            wb_rd_q        <= wb_rd_d;
            wb_pipe_stg_q  <= wb_pipe_stg_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_valid_q     <= wb_valid_d;
        end
    end

    // Data memory is flop-based so that reset can clear every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_store_en) begin
            mem_q[w_addr] <= store_data;
        end
    end

    assign wb_imm       = wb_imm_q;
    assign wb_result    = wb_result_q;
    assign wb_sel       = wb_sel_q;
    assign wb_rd        = wb_rd_q;
    assign wb_pipe_stg  = wb_pipe_stg_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_valid     = wb_valid_q;

    assign fwd_valid = wb_valid_q & wb_reg_write_q;
    assign fwd_rd    = wb_rd_q;
    assign fwd_data  = wb_sel_q ? wb_result_q : wb_imm_q;

endmodule
`default_nettype wire

// File: doc/mem_stg.md
Name: mem_stg

Overview:
- Memory stage of the 8-bit RISC pipeline. Sits between the execute stage and the write-back stage.
- Holds the data memory and performs loads and stores.
- Registers the MEM/WB pipeline latch that drives write-back: the immediate, the result, the select line, the destination register and the stage tag.
- Also drives a registered forwarding port back to execute.

Parameters:
- ADDR_W, 4, data-memory address width; memory depth = 2**ADDR_W bytes.
- DATA_W, 8, datapath width. Only 8 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage: no store, outputs held
- flush  in  1  squash the incoming instruction into a bubble
- valid_in  in  1  execute-stage instruction valid
- pipe_stg_in  in  4  opcode/stage tag from execute
- alu_result  in  8  ALU result; also the memory address for loads and stores
- store_data  in  8  register data for stores
- imm_in  in  8  load-immediate value
- rd_in  in  2  destination register
- mem_read  in  1  load
- mem_write  in  1  store
- wb_sel_in  in  1  0 = immediate to write-back, 1 = result
- reg_write_in  in  1  instruction writes the register file
- wb_imm  out  8  immediate to write-back (write-back select 0)
- wb_result  out  8  ALU or load result to write-back (write-back select 1)
- wb_sel  out  1  write-back mux select
- wb_rd  out  2  destination register
- wb_pipe_stg  out  4  stage tag passed on
- wb_reg_write  out  1  register-file write enable
- wb_valid  out  1  latch holds a real instruction
- fwd_valid  out  1  equals wb_valid & wb_reg_write
- fwd_rd  out  2  equals wb_rd
- fwd_data  out  8  equals wb_result when wb_sel=1, otherwise wb_imm

Behaviour:
- Reset:
  - When rst_n is low, all wb_* outputs are 0 immediately and the fwd_* outputs follow, so all are 0.
  - All 2**ADDR_W memory bytes clear to 0x00.
  - If reset arrives mid-operation, any in-flight store is lost. The first edge after rst_n rises is a normal cycle.
- Accept condition: accept = valid_in & ~stall & ~flush.
- Address: alu_result[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap (0x13 aliases 0x03 at ADDR_W=4).
- Store:
  - On a clock edge with accept & mem_write, mem[addr] <= store_data.
  - A store never writes the register file: wb_reg_write takes reg_write_in as given, and a store is expected to arrive with reg_write_in = 0.
- Load:
  - On a clock edge with accept & mem_read & ~mem_write, wb_result <= mem[addr], reading the memory contents before that edge.
  - Latency is 1 cycle: the load data is visible on wb_result the cycle after the instruction is presented.
- Store followed by load to the same address on the next cycle returns the new data, because the write was committed on the earlier edge.
- mem_read and mem_write both high is illegal. The store is performed and wb_result <= alu_result. No error flag is raised.
- Non-memory instruction: wb_result <= alu_result.
- Latch update on accept: wb_imm <= imm_in, wb_sel <= wb_sel_in, wb_rd <= rd_in, wb_pipe_stg <= pipe_stg_in, wb_reg_write <= reg_write_in, wb_valid <= 1.
- Stall (and no flush): every wb_* register holds its value and the memory is not written, so a held store is not committed twice.
- Flush: wins over stall. On the edge, wb_valid <= 0, wb_reg_write <= 0, and no store happens. The data fields may hold any value, but wb_reg_write = 0 must hold.
- valid_in = 0 with no stall or flush: same bubble result as flush.
- Forwarding outputs are combinational decodes of the latch only. There is no path from the stage inputs to the outputs.
- No combinational path from any input to any output except rst_n.

Test Plan:
- Reset: hold rst_n low with random inputs -> all outputs 0. Release, then load addr 0x05 -> wb_result = 0x00.
- Store then load: store 0xA5 to 0x03, next cycle load 0x03 -> wb_result = 0xA5, wb_rd = rd_in, wb_reg_write = 1 one cycle after the load.
- Wrap: store 0x3C to alu_result 0x13, then load 0x03 -> 0x3C.
- Stall: assert stall for 3 cycles during a store of 0x77 to 0x0F with store_data changed to 0x11 mid-stall -> outputs frozen and mem[0x0F] unchanged. Release with store_data = 0x77 -> mem[0x0F] = 0x77.
- Flush beats stall: stall = flush = 1 with a store of 0x99 to 0x02 -> wb_valid = 0, wb_reg_write = 0, a later load of 0x02 returns the old value.
- Load-immediate and forwarding: wb_sel_in = 0, imm_in = 0x42, rd_in = 2, reg_write_in = 1 -> next cycle wb_imm = 0x42, wb_sel = 0, fwd_valid = 1, fwd_rd = 2, fwd_data = 0x42. Assert rst_n low mid-cycle -> all outputs 0 at once.
